// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the seq detector: valid/ready word load, one bit per shift_en.
// Defining SER_LOOP_EN adds the loop_mode input, which recirculates the current word at its last bit.
module seq_serializer #(
    parameter int WIDTH     = 24,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         load_data,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic                     shift_en,
`ifdef SER_LOOP_EN
    input  logic                     loop_mode,
`endif
    output logic                     ser_out,
    output logic                     ser_valid,
    output logic                     last_bit,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH - 2);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [CW-1:0]    bit_cnt_reg;
    logic             ser_out_reg;
    logic             ser_valid_reg;
    logic             last_bit_reg;
    logic [WIDTH-1:0] rot_word;
    logic             loop_req;
    logic             load_ready_next;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // The word is rotated rather than shifted, so after WIDTH advances it is intact again for looping.
    generate
        if (MSB_FIRST) begin : g_rot_msb
            assign rot_word = {shreg_reg[WIDTH-2:0], shreg_reg[WIDTH-1]};
        end else begin : g_rot_lsb
            assign rot_word = {shreg_reg[0], shreg_reg[WIDTH-1:1]};
        end
    endgenerate

`ifdef SER_LOOP_EN
    assign loop_req = loop_mode;
`else
    assign loop_req = 1'b0;
`endif

    assign load_ready_next = (state_reg == IDLE) || (last_bit_reg && shift_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            bit_cnt_reg   <= '0;
            ser_out_reg   <= IDLE_BIT;
            ser_valid_reg <= 1'b0;
            last_bit_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_valid) begin
                        state_reg     <= SHIFT;
                        shreg_reg     <= load_data;
                        bit_cnt_reg   <= '0;
                        ser_out_reg   <= head_bit(load_data);
                        ser_valid_reg <= 1'b1;
                        last_bit_reg  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (!last_bit_reg) begin
                            shreg_reg    <= rot_word;
                            bit_cnt_reg  <= bit_cnt_reg + CW'(1);
                            ser_out_reg  <= head_bit(rot_word);
                            last_bit_reg <= (bit_cnt_reg == PENULT_IDX);
                        end else if (load_valid) begin
                            shreg_reg    <= load_data;
                            bit_cnt_reg  <= '0;
                            ser_out_reg  <= head_bit(load_data);
                            last_bit_reg <= 1'b0;
                        end else if (loop_req) begin
                            shreg_reg    <= rot_word;
                            bit_cnt_reg  <= '0;
                            ser_out_reg  <= head_bit(rot_word);
                            last_bit_reg <= 1'b0;
                        end else begin
                            state_reg     <= IDLE;
                            bit_cnt_reg   <= '0;
                            ser_out_reg   <= IDLE_BIT;
                            ser_valid_reg <= 1'b0;
                            last_bit_reg  <= 1'b0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign load_ready = load_ready_next;
    assign ser_out    = ser_out_reg;
    assign ser_valid  = ser_valid_reg;
    assign last_bit   = last_bit_reg && (bit_cnt_reg == LAST_IDX);
    assign bit_cnt    = bit_cnt_reg;
endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: word-stream reference model over a 24-bit MSB-first
// instance plus an 8-bit LSB-first instance; loop-mode steps run only when SER_LOOP_EN is defined.
module tb_seq_serializer;
    localparam int W = 24;

    logic         clk;
    logic         reset;
    logic [W-1:0] load_data;
    logic         load_valid;
    logic         load_ready;
    logic         shift_en;
    logic         ser_out;
    logic         ser_valid;
    logic         last_bit;
    logic [4:0]   bit_cnt;
`ifdef SER_LOOP_EN
    logic         loop_mode;
`endif

    logic [7:0]   d8_load_data;
    logic         d8_load_valid;
    logic         d8_load_ready;
    logic         d8_shift_en;
    logic         d8_ser_out;
    logic         d8_ser_valid;
    logic         d8_last_bit;
    logic [2:0]   d8_bit_cnt;

    int tests  = 0;
    int failed = 0;
    logic [W-1:0] wq[$];

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
`ifdef SER_LOOP_EN
        .loop_mode  (loop_mode),
`endif
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .last_bit   (last_bit),
        .bit_cnt    (bit_cnt)
    );

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut8 (
        .clk        (clk),
        .reset      (reset),
        .load_data  (d8_load_data),
        .load_valid (d8_load_valid),
        .load_ready (d8_load_ready),
        .shift_en   (d8_shift_en),
`ifdef SER_LOOP_EN
        .loop_mode  (1'b0),
`endif
        .ser_out    (d8_ser_out),
        .ser_valid  (d8_ser_valid),
        .last_bit   (d8_last_bit),
        .bit_cnt    (d8_bit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit k of a word in transmission order (MSB first for the 24-bit instance).
    function automatic logic word_bit(input logic [W-1:0] w, input int k);
        return w[W-1-k];
    endfunction

    // Streams every word in wq back to back. k counts accepted strobes since the first load,
    // so the word on the line is k/W and the bit within it is k%W.
    // en_mode: 0 = shift_en high, 1 = 0,1,0,1..., 2 = random. abort_at >= 0 returns early at that k.
    task automatic run_stream(input int en_mode, input int abort_at, input string tag);
        int  n;
        int  k;
        int  nxt;
        int  busy_cycles;
        bit  busy;
        n = wq.size();
        k = 0;
        busy = 1'b0;
        busy_cycles = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            nxt = busy ? (k / W) + 1 : 0;
            load_valid = (nxt < n);
            load_data  = (nxt < n) ? wq[nxt] : W'($urandom);
            if (!busy)
                shift_en = 1'($urandom);
            else if (en_mode == 0)
                shift_en = 1'b1;
            else if (en_mode == 1)
                shift_en = busy_cycles[0];
            else
                shift_en = 1'($urandom);
            #1;
            check({tag, "_ready"}, load_ready, (!busy || ((k % W == W - 1) && shift_en)));
            @(posedge clk);
            #1;
            if (!busy) begin
                busy = load_valid;
                k = 0;
            end else begin
                busy_cycles++;
                if (shift_en) begin
                    k++;
                    if (k == W * n) busy = 1'b0;
                end
            end
            if (busy) begin
                check({tag, "_valid"}, ser_valid, 1'b1);
                check({tag, "_bit"}, ser_out, word_bit(wq[k / W], k % W));
                check({tag, "_cnt"}, bit_cnt, k % W);
                check({tag, "_last"}, last_bit, (k % W == W - 1));
                if (k == abort_at) return;
            end else begin
                check({tag, "_idle_valid"}, ser_valid, 1'b0);
                check({tag, "_idle_out"}, ser_out, 1'b0);
                check({tag, "_idle_last"}, last_bit, 1'b0);
                if (en_mode < 2) check({tag, "_duration"}, busy_cycles, W * n * (en_mode + 1));
                $display("[TB] %s: %0d word(s), %0d busy cycles", tag, n, busy_cycles);
                return;
            end
        end
        check({tag, "_timeout"}, k, W * n);
    endtask

    initial begin
        logic [7:0] w8 [2];
        int n;
        reset = 1'b0;
        load_data = '0;
        load_valid = 1'b0;
        shift_en = 1'b0;
        d8_load_data = '0;
        d8_load_valid = 1'b0;
        d8_shift_en = 1'b0;
`ifdef SER_LOOP_EN
        loop_mode = 1'b0;
`endif
        #12;
        check("rst_ready", load_ready, 1'b1);
        check("rst_valid", ser_valid, 1'b0);
        check("rst_out", ser_out, 1'b0);
        check("rst_last", last_bit, 1'b0);
        check("rst_cnt", bit_cnt, 0);
        #8 reset = 1'b1;
        @(posedge clk);
        #1;

        wq = '{24'h0C9094};
        run_stream(0, -1, "t1_single");

        wq = '{24'hFFFFFF, 24'h000000};
        run_stream(0, -1, "t2_b2b");

        wq = '{24'hA5A5A5};
        run_stream(1, -1, "t3_toggle");

        for (int r = 0; r < 4; r++) begin
            wq.delete();
            n = 1 + $urandom_range(2);
            for (int i = 0; i < n; i++) wq.push_back(W'($urandom));
            run_stream(2, -1, "rand_en");
        end
        wq.delete();
        for (int i = 0; i < 3; i++) wq.push_back(W'($urandom));
        run_stream(0, -1, "rand_b2b");

        // Abort mid-word with an asynchronous reset.
        wq = '{24'h123456};
        run_stream(0, 10, "t4_pre");
        load_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("t4_async_valid", ser_valid, 1'b0);
        check("t4_async_out", ser_out, 1'b0);
        check("t4_async_cnt", bit_cnt, 0);
        check("t4_async_last", last_bit, 1'b0);
        check("t4_async_ready", load_ready, 1'b1);
        @(posedge clk);
        #3 reset = 1'b1;
        shift_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t4_post_valid", ser_valid, 1'b0);
            check("t4_post_out", ser_out, 1'b0);
        end
        $display("[TB] t4_reset_abort: done");

        // 8-bit LSB-first instance: 8'h01 then a random word back to back.
        w8[0] = 8'h01;
        w8[1] = 8'($urandom);
        d8_load_data = w8[0];
        d8_load_valid = 1'b1;
        d8_shift_en = 1'b1;
        @(posedge clk);
        #1;
        d8_load_data = w8[1];
        for (int k = 0; k < 16; k++) begin
            check("t5_valid", d8_ser_out === 1'bx ? 1'b0 : d8_ser_valid, 1'b1);
            check("t5_bit", d8_ser_out, (k < 8) ? ((w8[0] >> k) & 8'h1) : ((w8[1] >> (k - 8)) & 8'h1));
            check("t5_cnt", d8_bit_cnt, k % 8);
            check("t5_last", d8_last_bit, (k % 8 == 7));
            d8_load_valid = (k < 8);
            @(posedge clk);
            #1;
        end
        check("t5_idle_valid", d8_ser_valid, 1'b0);
        check("t5_idle_out", d8_ser_out, 1'b0);
        $display("[TB] t5_lsb8: words %02h %02h", w8[0], w8[1]);

`ifdef SER_LOOP_EN
        loop_mode = 1'b1;
        load_data = 24'h800001;
        load_valid = 1'b1;
        shift_en = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        for (int k = 0; k < 96; k++) begin
            check("t6_loop_valid", ser_valid, 1'b1);
            check("t6_loop_bit", ser_out, word_bit(24'h800001, k % W));
            check("t6_loop_cnt", bit_cnt, k % W);
            if (k == 95) begin
                load_data = 24'h000000;
                load_valid = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        loop_mode = 1'b0;
        load_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            check("t6_new_valid", ser_valid, 1'b1);
            check("t6_new_bit", ser_out, 1'b0);
            check("t6_new_cnt", bit_cnt, k);
            @(posedge clk);
            #1;
        end
        check("t6_idle_valid", ser_valid, 1'b0);
        $display("[TB] t6_loop: 4 periods then new word");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
